// File: rtl/isa_pkg.sv
// Shared instruction-format definitions for the imem loader: field widths,
// bit positions, opcode class boundaries and the loader FSM encoding.
package isa_pkg;
    localparam int OPW   = 3;
    localparam int REGW  = 5;
    localparam int ADDRW = 16;
    localparam int INSTW = 32;

    localparam int OP_LSB = 29;
    localparam int R0_LSB = 24;
    localparam int R1_LSB = 19;
    localparam int R2_LSB = 14;

    // Opcodes below OP_R1_MIN carry a full 16-bit addr; below OP_R2_MIN add r1.
    localparam logic [OPW-1:0] OP_R1_MIN = 3'd2;
    localparam logic [OPW-1:0] OP_R2_MIN = 3'd4;
    localparam logic [OPW-1:0] OP_NO_R1  = 3'd7;

    typedef struct packed {
        logic [OPW-1:0]   opcode;
        logic [REGW-1:0]  reg_addr_0;
        logic [REGW-1:0]  reg_addr_1;
        logic [REGW-1:0]  reg_addr_2;
        logic [ADDRW-1:0] addr;
    } inst_fields_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } load_state_e;
endpackage

// File: rtl/inst_pack.sv
// Combinational field packer: decoded fields -> 32-bit instruction word,
// flagging an addr that does not fit the opcode's immediate field.
module inst_pack
    import isa_pkg::*;
(
    input  inst_fields_t     fields,
    output logic [INSTW-1:0] word,
    output logic             range_err
);
    always_comb begin
        word      = '0;
        range_err = 1'b0;
        word[OP_LSB +: OPW]  = fields.opcode;
        word[R0_LSB +: REGW] = fields.reg_addr_0;
        if (fields.opcode < OP_R1_MIN) begin
            word[ADDRW-1:0] = fields.addr;
        end else if (fields.opcode < OP_R2_MIN) begin
            word[R1_LSB +: REGW] = fields.reg_addr_1;
            word[14:0]           = fields.addr[14:0];
            range_err            = fields.addr[15];
        end else begin
            if (fields.opcode != OP_NO_R1)
                word[R1_LSB +: REGW] = fields.reg_addr_1;
            word[R2_LSB +: REGW] = fields.reg_addr_2;
            word[13:0]           = fields.addr[13:0];
            range_err            = |fields.addr[15:14];
        end
    end
endmodule

// File: rtl/inst_encoder_loader.sv
// Streams decoded field tuples into imem as packed words starting at base_addr,
// with a one-stage write register, session FSM and sticky error capture.
module inst_encoder_loader
    import isa_pkg::*;
#(
    parameter int IMEM_AW    = 8,
    parameter int IMEM_DEPTH = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [IMEM_AW-1:0]   base_addr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic [OPW-1:0]       opcode,
    input  logic [REGW-1:0]      reg_addr_0,
    input  logic [REGW-1:0]      reg_addr_1,
    input  logic [REGW-1:0]      reg_addr_2,
    input  logic [ADDRW-1:0]     addr,
    output logic                 imem_we,
    output logic [IMEM_AW-1:0]   imem_waddr,
    output logic [INSTW-1:0]     imem_wdata,
    output logic                 busy,
    output logic                 done,
    output logic [IMEM_AW:0]     inst_count,
    output logic                 err_range,
    output logic                 err_ovf,
    output logic [IMEM_AW:0]     err_index
);
    // A full-size imem wraps its address; a partial one stops at IMEM_DEPTH.
    localparam bit                 WRAP    = (IMEM_DEPTH == (1 << IMEM_AW));
    localparam logic [IMEM_AW+1:0] DEPTH_W = (IMEM_AW+2)'(IMEM_DEPTH);

    load_state_e        state_q, state_d;
    logic [IMEM_AW-1:0] base_q;
    logic [IMEM_AW:0]   k_q;
    logic [IMEM_AW+1:0] widx;
    logic               accept, ovf_now, pack_rerr;
    logic [INSTW-1:0]   pack_word;
    inst_fields_t       fields;

    assign fields = '{opcode: opcode, reg_addr_0: reg_addr_0, reg_addr_1: reg_addr_1,
                      reg_addr_2: reg_addr_2, addr: addr};

    inst_pack u_pack (
        .fields    (fields),
        .word      (pack_word),
        .range_err (pack_rerr)
    );

    assign in_ready = (state_q == S_LOAD);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign accept   = in_valid && in_ready;
    assign widx     = {2'b00, base_q} + {1'b0, k_q};
    assign ovf_now  = !WRAP && (widx >= DEPTH_W);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD:  if (accept && in_last) state_d = S_DRAIN;
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            k_q        <= '0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            inst_count <= '0;
            err_range  <= 1'b0;
            err_ovf    <= 1'b0;
            err_index  <= '0;
        end else begin
            state_q <= state_d;
            imem_we <= 1'b0;
            if (start && state_q == S_IDLE) begin
                base_q     <= base_addr;
                k_q        <= '0;
                inst_count <= '0;
                err_range  <= 1'b0;
                err_ovf    <= 1'b0;
                err_index  <= '0;
            end
            if (accept) begin
                k_q <= k_q + 1'b1;
                if (!ovf_now) begin
                    imem_we    <= 1'b1;
                    imem_waddr <= widx[IMEM_AW-1:0];
                    imem_wdata <= pack_word;
                    inst_count <= inst_count + 1'b1;
                end
                if (pack_rerr) err_range <= 1'b1;
                if (ovf_now)   err_ovf   <= 1'b1;
                // Only the first offending tuple is recorded.
                if ((pack_rerr || ovf_now) && !err_range && !err_ovf)
                    err_index <= k_q;
            end
        end
    end
endmodule

// File: tb/tb_inst_encoder_loader.sv
// Directed bench for inst_encoder_loader using a 12-word imem (IMEM_AW=4) so
// the overflow boundary is reachable; packed words are checked by decoding.
module tb_inst_encoder_loader;
    localparam int AW    = 4;
    localparam int DEPTH = 12;

    logic          clk = 1'b0;
    logic          rst, start, in_valid, in_ready, in_last;
    logic [AW-1:0] base_addr;
    logic [2:0]    opcode;
    logic [4:0]    reg_addr_0, reg_addr_1, reg_addr_2;
    logic [15:0]   addr;
    logic          imem_we, busy, done, err_range, err_ovf;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   inst_count, err_index;

    int checks = 0;
    int errors = 0;

    inst_encoder_loader #(.IMEM_AW(AW), .IMEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .opcode(opcode), .reg_addr_0(reg_addr_0), .reg_addr_1(reg_addr_1),
        .reg_addr_2(reg_addr_2), .addr(addr), .imem_we(imem_we),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .busy(busy),
        .done(done), .inst_count(inst_count), .err_range(err_range),
        .err_ovf(err_ovf), .err_index(err_index)
    );

    always #5 clk = ~clk;

    task automatic set_tuple(input logic [2:0] op, input logic [4:0] r0, r1, r2,
                             input logic [15:0] a, input logic v, input logic l);
        opcode = op; reg_addr_0 = r0; reg_addr_1 = r1; reg_addr_2 = r2;
        addr = a; in_valid = v; in_last = l;
    endtask

    task automatic begin_session(input logic [AW-1:0] b);
        @(negedge clk);
        start = 1'b1; base_addr = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; base_addr = '0;
        set_tuple(3'd0, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if ({imem_we, imem_waddr, imem_wdata, busy, done, inst_count, err_range, err_ovf, err_index, in_ready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: we=%b waddr=%0d wdata=%h busy=%b done=%b cnt=%0d er=%b eo=%b ei=%0d rdy=%b, required all 0",
                     imem_we, imem_waddr, imem_wdata, busy, done, inst_count, err_range, err_ovf, err_index, in_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_single;
        begin_session(4'd0);
        set_tuple(3'd1, 5'd5, 5'd0, 5'd0, 16'hBEEF, 1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (imem_we !== 1'b1 || imem_waddr !== 4'd0 || imem_wdata !== 32'h2500BEEF) begin
            errors++;
            $display("FAIL single_write: we=%b waddr=%0d wdata=%h, required we=1 waddr=0 wdata=2500beef", imem_we, imem_waddr, imem_wdata);
        end
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_drain: done=%b busy=%b, required done=0 busy=1", done, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || inst_count !== 5'd1 || imem_we !== 1'b0) begin
            errors++;
            $display("FAIL single_done: done=%b cnt=%0d we=%b, required done=1 cnt=1 we=0", done, inst_count, imem_we);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || inst_count !== 5'd1) begin
            errors++;
            $display("FAIL single_idle: done=%b busy=%b cnt=%0d, required 0 0 1", done, busy, inst_count);
        end
    endtask

    task automatic test_formats;
        begin_session(4'd0);
        set_tuple(3'd4, 5'd1, 5'd2, 5'd3, 16'd5, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (imem_we !== 1'b1 || imem_wdata !== 32'h8110C005 || err_range !== 1'b0 || err_ovf !== 1'b0) begin
            errors++;
            $display("FAIL fmt_op4: we=%b wdata=%h er=%b eo=%b, required 1 8110c005 0 0", imem_we, imem_wdata, err_range, err_ovf);
        end
        set_tuple(3'd7, 5'd0, 5'd31, 5'd4, 16'h3FFF, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (imem_we !== 1'b1 || imem_waddr !== 4'd1 || imem_wdata !== 32'hE0013FFF || err_range !== 1'b0) begin
            errors++;
            $display("FAIL fmt_op7: we=%b waddr=%0d wdata=%h er=%b, required 1 1 e0013fff 0", imem_we, imem_waddr, imem_wdata, err_range);
        end
        set_tuple(3'd2, 5'd0, 5'd0, 5'd0, 16'h8001, 1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (imem_we !== 1'b1 || imem_waddr !== 4'd2 || imem_wdata !== 32'h40000001) begin
            errors++;
            $display("FAIL fmt_op2_trunc: we=%b waddr=%0d wdata=%h, required 1 2 40000001", imem_we, imem_waddr, imem_wdata);
        end
        checks++;
        if (err_range !== 1'b1 || err_ovf !== 1'b0 || err_index !== 5'd2) begin
            errors++;
            $display("FAIL fmt_range_err: er=%b eo=%b ei=%0d, required 1 0 2", err_range, err_ovf, err_index);
        end
        repeat (2) @(negedge clk);
        // A fresh start clears the sticky errors.
        begin_session(4'd0);
        checks++;
        if (err_range !== 1'b0 || err_index !== 5'd0 || inst_count !== 5'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_clears: er=%b ei=%0d cnt=%0d busy=%b, required 0 0 0 1", err_range, err_index, inst_count, busy);
        end
        set_tuple(3'd0, 5'd0, 5'd0, 5'd0, 16'h0, 1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        begin_session(4'd5);
        // A start while loading must not move the base.
        start = 1'b1; base_addr = 4'd9;
        for (int i = 0; i < 3; i++) begin
            set_tuple(3'd0, 5'(i), 5'd0, 5'd0, 16'(i + 16'h100), 1'b1, i == 2);
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (imem_we !== 1'b1 || imem_waddr !== 4'(5 + i) || imem_wdata !== {3'd0, 5'(i), 8'd0, 16'(i + 16'h100)}) begin
                errors++;
                $display("FAIL b2b_write%0d: we=%b waddr=%0d wdata=%h, required we=1 waddr=%0d", i, imem_we, imem_waddr, imem_wdata, 5 + i);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || inst_count !== 5'd3) begin
            errors++;
            $display("FAIL b2b_done: done=%b cnt=%0d, required 1 3", done, inst_count);
        end
        @(negedge clk);
    endtask

    task automatic test_overflow;
        begin_session(4'd10);
        for (int i = 0; i < 4; i++) begin
            set_tuple(3'd1, 5'd3, 5'd0, 5'd0, 16'(i), 1'b1, i == 3);
            @(negedge clk);
            checks++;
            if (imem_we !== (i < 2) || (i < 2 && imem_waddr !== 4'(10 + i))) begin
                errors++;
                $display("FAIL ovf_write%0d: we=%b waddr=%0d, required we=%b waddr=%0d", i, imem_we, imem_waddr, i < 2, 10 + i);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (err_ovf !== 1'b1 || err_range !== 1'b0 || err_index !== 5'd2 || inst_count !== 5'd2) begin
            errors++;
            $display("FAIL ovf_flags: eo=%b er=%b ei=%0d cnt=%0d, required 1 0 2 2", err_ovf, err_range, err_index, inst_count);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL ovf_done: done=%b, required 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int seen_done = 0;
        begin_session(4'd0);
        set_tuple(3'd1, 5'd1, 5'd0, 5'd0, 16'h1234, 1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (imem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || inst_count !== 5'd0) begin
            errors++;
            $display("FAIL rst_mid: we=%b busy=%b done=%b cnt=%0d, required 0 0 0 0", imem_we, busy, done, inst_count);
        end
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1 || imem_we === 1'b1) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL rst_no_done: activity cycles=%0d, required 0", seen_done);
        end
        begin_session(4'd3);
        set_tuple(3'd5, 5'd2, 5'd3, 5'd4, 16'h0010, 1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (imem_we !== 1'b1 || imem_waddr !== 4'd3 || imem_wdata !== 32'hA2190010) begin
            errors++;
            $display("FAIL rst_restart: we=%b waddr=%0d wdata=%h, required 1 3 a2190010", imem_we, imem_waddr, imem_wdata);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_roundtrip;
        logic [2:0]  op[10];
        logic [4:0]  r0[10], r1[10], r2[10];
        logic [15:0] a[10];
        logic [4:0]  e1, e2;
        logic [15:0] ea;
        logic        any_rerr = 1'b0;
        logic [15:0] rsv;
        for (int i = 0; i < 10; i++) begin
            op[i] = 3'($urandom_range(0, 7));
            r0[i] = 5'($urandom); r1[i] = 5'($urandom); r2[i] = 5'($urandom);
            a[i]  = 16'($urandom);
        end
        begin_session(4'd0);
        for (int i = 0; i < 10; i++) begin
            set_tuple(op[i], r0[i], r1[i], r2[i], a[i], 1'b1, i == 9);
            @(negedge clk);
            e1 = (op[i] >= 2 && op[i] <= 6) ? r1[i] : 5'd0;
            e2 = (op[i] >= 4) ? r2[i] : 5'd0;
            ea = (op[i] < 2) ? a[i] : (op[i] < 4) ? (a[i] & 16'h7FFF) : (a[i] & 16'h3FFF);
            if ((op[i] >= 2 && op[i] < 4 && a[i][15]) || (op[i] >= 4 && a[i][15:14] != 2'b00)) any_rerr = 1'b1;
            // Bits the format leaves unused must read back as zero.
            rsv = (op[i] < 2) ? {8'd0, imem_wdata[23:16]} : (op[i] < 4) ? {12'd0, imem_wdata[18:15]} : 16'd0;
            checks++;
            if (imem_we !== 1'b1 || imem_waddr !== 4'(i) || imem_wdata[31:29] !== op[i] || imem_wdata[28:24] !== r0[i]
                || (op[i] >= 2 && imem_wdata[23:19] !== e1) || (op[i] >= 4 && imem_wdata[18:14] !== e2)
                || ((op[i] < 2 ? imem_wdata[15:0] : op[i] < 4 ? {1'b0, imem_wdata[14:0]} : {2'b0, imem_wdata[13:0]}) !== ea)
                || rsv !== 16'd0) begin
                errors++;
                $display("FAIL roundtrip%0d: we=%b waddr=%0d wdata=%h, required op=%0d r0=%0d r1=%0d r2=%0d addr=%h",
                         i, imem_we, imem_waddr, imem_wdata, op[i], r0[i], e1, e2, ea);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (err_range !== any_rerr) begin
            errors++;
            $display("FAIL roundtrip_err: er=%b, required %b", err_range, any_rerr);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_single;
        test_formats;
        test_back_to_back;
        test_overflow;
        test_reset_mid;
        test_roundtrip;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
